// File: rtl/seven_seg_pkg.sv
// Constants and types shared by the seven-segment encoder and the scan driver.
package seven_seg_pkg;

  localparam logic [7:0]  SEG_BLANK  = 8'hFF;
  localparam int unsigned NUM_DIGITS = 4;
  localparam logic [3:0]  DIGIT_OFF  = 4'hF;

  typedef enum logic [1:0] {
    PH_BLANK,
    PH_LIT,
    PH_DARK
  } phase_e;

endpackage

// File: rtl/seg_scan_timer.sv
// Slot counter and digit index for the scan; frame_tick marks the snapshot cycle.
module seg_scan_timer
  import seven_seg_pkg::*;
#(
  parameter int unsigned BLANK_CYCLES = 50,
  parameter int unsigned DIGIT_CYCLES = 100000,
  parameter int unsigned CNT_W        = $clog2(BLANK_CYCLES + DIGIT_CYCLES)
) (
  input  logic                          clk,
  input  logic                          rstn,
  input  logic                          enable,
  output logic [$clog2(NUM_DIGITS)-1:0] d,
  output logic [CNT_W-1:0]              cnt,
  output logic                          frame_tick
);

  localparam int unsigned DW = $clog2(NUM_DIGITS);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(BLANK_CYCLES + DIGIT_CYCLES - 1);

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [DW-1:0]    d_q, d_d;

  always_comb begin
    cnt_d = cnt_q;
    d_d   = d_q;
    if (!enable) begin
      cnt_d = '0;
      d_d   = '0;
    end else if (cnt_q == CNT_MAX) begin
      cnt_d = '0;
      d_d   = d_q + DW'(1);
    end else begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      cnt_q <= '0;
      d_q   <= '0;
    end else begin
      cnt_q <= cnt_d;
      d_q   <= d_d;
    end
  end

  assign d          = d_q;
  assign cnt        = cnt_q;
  assign frame_tick = enable && (d_q == '0) && (cnt_q == '0);

endmodule

// File: rtl/seven_seg_scan.sv
// Time-multiplexed 4-digit driver: per-frame input snapshot, blanking gap, dimmable lit phase.
module seven_seg_scan
  import seven_seg_pkg::*;
#(
  parameter int unsigned BLANK_CYCLES = 50,
  parameter int unsigned DIGIT_CYCLES = 100000
) (
  input  logic       clk,
  input  logic       rstn,
  input  logic       enable,
  input  logic [1:0] dim,
  input  logic [7:0] seg_in_1,
  input  logic [7:0] seg_in_2,
  input  logic [7:0] seg_in_3,
  input  logic [7:0] seg_in_4,
  output logic [7:0] seg_out,
  output logic [3:0] digit_en,
  output logic       frame_start
);

  localparam int unsigned CNT_W   = $clog2(BLANK_CYCLES + DIGIT_CYCLES);
  localparam int unsigned DW      = $clog2(NUM_DIGITS);
  localparam int unsigned QUARTER = DIGIT_CYCLES / 4;

  logic [DW-1:0]    d;
  logic [CNT_W-1:0] cnt;
  logic             frame_tick;

  logic [7:0] snap_q [NUM_DIGITS];
  logic [7:0] snap_d [NUM_DIGITS];
  logic [1:0] dim_q, dim_d;
  logic [7:0] seg_out_q, seg_out_d;
  logic [3:0] digit_en_q, digit_en_d;
  logic       frame_start_q, frame_start_d;

  logic [31:0] cnt_ext;
  logic [31:0] on_cycles;
  phase_e      phase;

  seg_scan_timer #(
    .BLANK_CYCLES (BLANK_CYCLES),
    .DIGIT_CYCLES (DIGIT_CYCLES),
    .CNT_W        (CNT_W)
  ) u_timer (
    .clk        (clk),
    .rstn       (rstn),
    .enable     (enable),
    .d          (d),
    .cnt        (cnt),
    .frame_tick (frame_tick)
  );

  always_comb begin
    snap_d = snap_q;
    dim_d  = dim_q;
    if (frame_tick) begin
      snap_d[0] = seg_in_1;
      snap_d[1] = seg_in_2;
      snap_d[2] = seg_in_3;
      snap_d[3] = seg_in_4;
      dim_d     = dim;
    end
  end

  // The snapshot cycle always falls in BLANK (cnt=0), so decoding against the
  // pre-snapshot dim_q/snap_q never produces a visible mix of old and new data.
  always_comb begin
    cnt_ext   = 32'(cnt);
    on_cycles = QUARTER * (32'(dim_q) + 32'd1);
    if (cnt_ext < BLANK_CYCLES) begin
      phase = PH_BLANK;
    end else if (cnt_ext < BLANK_CYCLES + on_cycles) begin
      phase = PH_LIT;
    end else begin
      phase = PH_DARK;
    end

    seg_out_d     = SEG_BLANK;
    digit_en_d    = DIGIT_OFF;
    frame_start_d = frame_tick;
    if (enable && phase == PH_LIT) begin
      seg_out_d  = snap_q[d];
      digit_en_d = ~(4'b0001 << d);
    end
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      snap_q        <= '{default: SEG_BLANK};
      dim_q         <= 2'd3;
      seg_out_q     <= SEG_BLANK;
      digit_en_q    <= DIGIT_OFF;
      frame_start_q <= 1'b0;
    end else begin
      snap_q        <= snap_d;
      dim_q         <= dim_d;
      seg_out_q     <= seg_out_d;
      digit_en_q    <= digit_en_d;
      frame_start_q <= frame_start_d;
    end
  end

  assign seg_out     = seg_out_q;
  assign digit_en    = digit_en_q;
  assign frame_start = frame_start_q;

endmodule

// File: doc/seven_seg_scan.md
# seven_seg_scan

Time-multiplexed display driver sitting directly downstream of `seven_seg`. It consumes the four 8-bit active-low segment patterns (`seven_seg_1`..`seven_seg_4`, bit 7 = decimal point) and drives one shared segment bus plus four active-low digit enables on the camera board. Each digit is scanned in turn with a blanking gap to suppress ghosting. The four input patterns and the dimming level are snapshotted once per frame, so a digit never changes mid-frame.

## Interface
- `BLANK_CYCLES`, default 50: cycles of all-off gap before each digit; must be ≥1.
- `DIGIT_CYCLES`, default 100000: cycles of the digit slot after the gap; must be a multiple of 4 and ≥4.
- `clk` input, 1 bit: system clock; the only clock.
- `rstn` input, 1 bit: reset, synchronous and active-low.
- `enable` input, 1 bit: 1 = scan; 0 = display dark and scan held at frame start.
- `dim` input, 2 bits: lit duty within a digit slot is `(dim+1)/4`.
- `seg_in_1`..`seg_in_4` input, 8 bits each: active-low patterns from `seven_seg`; `seg_in_1` is the rightmost digit.
- `seg_out` output, 8 bits: shared active-low segment bus.
- `digit_en` output, 4 bits: active-low digit enables; bit i selects `seg_in_(i+1)`.
- `frame_start` output, 1 bit: one-cycle pulse marking a new input snapshot.

## Operation
- Internal state:
  - digit index `d` (0..3);
  - slot counter `cnt` (0..`BLANK_CYCLES+DIGIT_CYCLES-1`);
  - snapshot registers `snap[0..3]`;
  - `dim_q`.
- `ON_CYCLES = (DIGIT_CYCLES/4)*(dim_q+1)`.
- Counter sequencing, while `enable`=1:
  - `cnt` increments each cycle.
  - At its maximum, `cnt` wraps to 0 and `d` advances.
  - `d` wraps 3→0, which starts a new frame.
- Phases within a slot:
  - BLANK: `cnt` < `BLANK_CYCLES`.
  - LIT: `BLANK_CYCLES` ≤ `cnt` < `BLANK_CYCLES+ON_CYCLES`.
  - DARK: the remainder of the slot. DARK is empty when `dim_q`=3.
- Snapshot: on every cycle with `enable`=1, `d`=0 and `cnt`=0, capture `seg_in_1..4` into `snap[0..3]` and `dim` into `dim_q`. Inputs are ignored at all other times.
- Output decode:
  - LIT: `seg_out`=`snap[d]`, `digit_en`=~(1<<d).
  - BLANK or DARK: `seg_out`=8'hFF, `digit_en`=4'hF.
- At most one `digit_en` bit is ever low.
- `enable`=0:
  - `cnt` and `d` are forced to 0.
  - Outputs go dark on the next edge.
  - `frame_start`=0.
  - Snapshot registers keep their values.
  - When `enable` returns to 1, the first enabled cycle is a snapshot cycle.
- Reset (`rstn`=0 at an edge), from any state including mid-slot:
  - `cnt`=0, `d`=0.
  - `snap[*]`=8'hFF, `dim_q`=3.
  - `seg_out`=8'hFF, `digit_en`=4'hF, `frame_start`=0.
- The first cycle after reset release with `enable`=1 is a snapshot cycle.
- Input changes do not affect the current frame. The first affected output is digit 0 LIT of the next frame.

## Timing
- All outputs are registered. Outputs reflect the `cnt`/`d` phase of the previous cycle, so there is one cycle of latency.
- `frame_start` is high in the cycle after the snapshot edge, for exactly one cycle.
- For digit 0, the first LIT output appears `BLANK_CYCLES+1` cycles after the snapshot edge.
- Frame period is `4*(BLANK_CYCLES+DIGIT_CYCLES)` cycles, independent of `dim`.
- `frame_start` pulses are spaced exactly one frame period apart while `enable` stays 1.
- Lit cycles per digit per frame = `ON_CYCLES`, which is contiguous.

## Structure
- Shared package `seven_seg_pkg` holds:
  - `SEG_BLANK` = 8'hFF;
  - `NUM_DIGITS` = 4;
  - `DIGIT_OFF` = 4'hF.
- These constants are also used by `seven_seg`.
- One sub-module: `seg_scan_timer`.
  - Contains the `cnt`/`d` counters.
  - Outputs `d`, `cnt` and a `frame_tick` (=`d`==0 && `cnt`==0 && `enable`).
  - Takes `clk`, `rstn`, `enable`.
- The top level holds the snapshot registers and the registered phase decode.

## Test plan
- **Reset values and first LIT.**
  - Stimulus: BLANK=2, DIGIT=8, `dim`=3, inputs 8'hC0/8'hF9/8'hA4/8'hB0, release reset.
  - Response: `frame_start` is high on cycle 1. From cycle 3, `seg_out`=8'hC0 and `digit_en`=4'hE for 8 cycles. After a 2-cycle gap, `seg_out`=8'hF9 and `digit_en`=4'hD.
- **Dimming.**
  - Stimulus: `dim`=0, same parameters.
  - Response: each digit is LIT for 2 cycles and dark for 8; the frame period stays 40.
- **Snapshot isolation.**
  - Stimulus: change `seg_in_3` to 8'h82 during digit 1 LIT.
  - Response: digit 2 still shows 8'hA4 this frame and shows 8'h82 next frame.
- **Enable drop mid-slot.**
  - Stimulus: drop `enable` during digit 2 LIT, hold it low 5 cycles, then re-raise.
  - Response: outputs go dark one cycle after the drop. On re-raise, a snapshot occurs, `frame_start` pulses, and the scan restarts at digit 0.
- **Reset mid-frame.**
  - Stimulus: assert `rstn`=0 during digit 3 LIT.
  - Response: on the next edge, `seg_out`=8'hFF, `digit_en`=4'hF and `frame_start`=0. After release, the scan restarts at digit 0.
- **Exclusivity check.**
  - Stimulus: 1000-cycle random run with random `dim` and `enable`.
  - Response: never more than one `digit_en` bit is low, and `seg_out`=8'hFF whenever `digit_en`=4'hF.
